// File: rtl/pio_pkg.sv
// Shared definitions for the PIO GPIO controller: register addresses, edge
// selection codes and the debounce counter width helper.
package pio_pkg;

  typedef enum logic [2:0] {
    PIO_ADDR_DATA    = 3'd0,
    PIO_ADDR_IRQMASK = 3'd1,
    PIO_ADDR_EDGECAP = 3'd2,
    PIO_ADDR_OUTSET  = 3'd3,
    PIO_ADDR_OUTCLR  = 3'd4
  } pio_addr_e;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

  // Bits needed to count 0..n; never narrower than one bit.
  function automatic int pio_cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pio_input_cond.sv
// Input conditioning for the PIO: per-bit synchronizer, followed by an
// optional per-bit debounce filter enabled by defining PIO_DEBOUNCE_EN.
module pio_input_cond
  import pio_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] din
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  // NOTE: every synchronizer stage is reset, not just the last one, so the
  // first edge seen after reset is fully deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int                CNT_W    = pio_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] din_q;

  // A bit flips only on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q <= '0;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sync_out[b] == din_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          din_q[b] <= sync_out[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign din = din_q;
`else
  localparam int DEBOUNCE_UNUSED = DEBOUNCE_CYCLES;
  assign din = sync_out;
`endif

endmodule

// File: rtl/pio_gpio_ctrl.sv
// Avalon-MM parallel I/O slave: output register with set/clear aliases, edge
// capture on conditioned inputs and a maskable level interrupt.
// Optional input debounce is enabled by defining PIO_DEBOUNCE_EN.
module pio_gpio_ctrl
  import pio_pkg::*;
#(
  parameter int               WIDTH           = 5,
  parameter logic [WIDTH-1:0] OUT_RESET       = '0,
  parameter int               EDGE_TYPE       = PIO_EDGE_RISE,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      wdata_unused;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] rd_next;

  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign wdata_unused = writedata;

  pio_input_cond #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_input_cond (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .din     (din)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      PIO_EDGE_RISE: edge_hit = din & ~din_d;
      PIO_EDGE_FALL: edge_hit = ~din & din_d;
      default:       edge_hit = din ^ din_d;
    endcase
  end

  assign cap_clr = (wr_en && address == PIO_ADDR_EDGECAP) ? wdata : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= OUT_RESET;
      mask_q <= '0;
    end else if (wr_en) begin
      case (address)
        PIO_ADDR_DATA:    out_q  <= wdata;
        PIO_ADDR_IRQMASK: mask_q <= wdata;
        PIO_ADDR_OUTSET:  out_q  <= out_q | wdata;
        PIO_ADDR_OUTCLR:  out_q  <= out_q & ~wdata;
        default:          ;
      endcase
    end
  end

  // A new edge wins over a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
      din_d <= '0;
    end else begin
      cap_q <= (cap_q & ~cap_clr) | edge_hit;
      din_d <= din;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA:    rd_next = din;
      PIO_ADDR_IRQMASK: rd_next = mask_q;
      PIO_ADDR_EDGECAP: rd_next = cap_q;
      default:          rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= 32'(rd_next);
  end

  assign out_port = out_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Self-checking bench for pio_gpio_ctrl: three instances (rising, any, falling
// edge) share one bus and input stream and are compared to a reference model.
`timescale 1ns/1ps
module tb_pio_gpio_ctrl;

  localparam int N  = 3;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address    = '0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [4:0]  in_port    = '0;

  logic [4:0]  out_p [N];
  logic        irq_v [N];
  logic [31:0] rd_v  [N];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pio_gpio_ctrl #(.WIDTH(5), .OUT_RESET(5'h00), .EDGE_TYPE(0), .SYNC_STAGES(2),
                  .DEBOUNCE_CYCLES(DB)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_v[0]),
    .in_port(in_port), .out_port(out_p[0]), .irq(irq_v[0]));

  pio_gpio_ctrl #(.WIDTH(5), .OUT_RESET(5'h0A), .EDGE_TYPE(2), .SYNC_STAGES(3),
                  .DEBOUNCE_CYCLES(DB)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_v[1]),
    .in_port(in_port), .out_port(out_p[1]), .irq(irq_v[1]));

  pio_gpio_ctrl #(.WIDTH(5), .OUT_RESET(5'h15), .EDGE_TYPE(1), .SYNC_STAGES(4),
                  .DEBOUNCE_CYCLES(DB)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_v[2]),
    .in_port(in_port), .out_port(out_p[2]), .irq(irq_v[2]));

  function automatic int cfg_edge(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 1;
  endfunction

  function automatic int cfg_sync(input int i);
    return i + 2;
  endfunction

  function automatic logic [4:0] cfg_rst(input int i);
    return (i == 0) ? 5'h00 : (i == 1) ? 5'h0A : 5'h15;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: behaviour written from the register-map rules.
  logic [4:0]  m_out [N], m_mask [N], m_cap [N], m_din [N], m_dprev [N];
  logic [31:0] m_rd [N];
  logic [4:0]  in_hist [4];
  logic [4:0]  s_hist [N][DB];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) in_hist[k] = '0;
    for (int i = 0; i < N; i++) begin
      m_out[i] = cfg_rst(i); m_mask[i] = '0; m_cap[i] = '0;
      m_din[i] = '0; m_dprev[i] = '0; m_rd[i] = '0;
      for (int k = 0; k < DB; k++) s_hist[i][k] = '0;
    end
  endtask

  task automatic model_step();
    logic       wr;
    logic [4:0] wd, e, clr;
    wr = chipselect && !write_n;
    wd = writedata[4:0];
    for (int i = 0; i < N; i++) begin
      case (cfg_edge(i))
        0:       e = m_din[i] & ~m_dprev[i];
        1:       e = ~m_din[i] & m_dprev[i];
        default: e = m_din[i] ^ m_dprev[i];
      endcase
      case (address)
        3'd0:    m_rd[i] = {27'd0, m_din[i]};
        3'd1:    m_rd[i] = {27'd0, m_mask[i]};
        3'd2:    m_rd[i] = {27'd0, m_cap[i]};
        default: m_rd[i] = '0;
      endcase
      clr = (wr && address == 3'd2) ? wd : 5'd0;
      m_cap[i] = (m_cap[i] & ~clr) | e;
      if (wr) begin
        case (address)
          3'd0: m_out[i] = wd;
          3'd1: m_mask[i] = wd;
          3'd3: m_out[i] = m_out[i] | wd;
          3'd4: m_out[i] = m_out[i] & ~wd;
          default: ;
        endcase
      end
      m_dprev[i] = m_din[i];
`ifdef PIO_DEBOUNCE_EN
      begin
        logic [4:0] all_diff;
        for (int k = DB - 1; k > 0; k--) s_hist[i][k] = s_hist[i][k-1];
        s_hist[i][0] = in_hist[cfg_sync(i) - 1];
        all_diff = '1;
        for (int k = 0; k < DB; k++) all_diff = all_diff & (s_hist[i][k] ^ m_din[i]);
        m_din[i] = m_din[i] ^ all_diff;
      end
`endif
    end
    for (int k = 3; k > 0; k--) in_hist[k] = in_hist[k-1];
    in_hist[0] = in_port;
`ifndef PIO_DEBOUNCE_EN
    for (int i = 0; i < N; i++) m_din[i] = in_hist[cfg_sync(i) - 1];
`endif
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("out%0d", i), {27'd0, out_p[i]}, {27'd0, m_out[i]});
        check($sformatf("irq%0d", i), {31'd0, irq_v[i]}, {31'd0, |(m_cap[i] & m_mask[i])});
        check($sformatf("rd%0d", i), rd_v[i], m_rd[i]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    check("rst_out0", {27'd0, out_p[0]}, 32'h0);
    check("rst_out1", {27'd0, out_p[1]}, 32'h0A);
    check("rst_irq0", {31'd0, irq_v[0]}, 32'h0);
    address = 3'd0; in_port = 5'b00000;
    tick();
    check("rd_data_rst", rd_v[0], 32'h0);

    bus_write(3'd0, 32'hFFFF_FF1F);
    check("wr_data", {27'd0, out_p[0]}, 32'h1F);
    bus_write(3'd4, 32'h05);
    check("wr_outclr", {27'd0, out_p[0]}, 32'h1A);
    bus_write(3'd3, 32'h01);
    check("wr_outset", {27'd0, out_p[0]}, 32'h1B);
    address = 3'd3; tick();
    check("rd_outset", rd_v[0], 32'h0);
    address = 3'd4; tick();
    check("rd_outclr", rd_v[0], 32'h0);

`ifndef PIO_DEBOUNCE_EN
    bus_write(3'd1, 32'h04);
    in_port = 5'b00100;
    tick(); tick();
    check("edge_early", {31'd0, irq_v[0]}, 32'h0);
    tick();
    check("edge_irq", {31'd0, irq_v[0]}, 32'h1);
    address = 3'd2; tick();
    check("edge_cap", rd_v[0], 32'h04);
    bus_write(3'd2, 32'h04);
    check("cap_clr_irq", {31'd0, irq_v[0]}, 32'h0);
    in_port = 5'b00000;
    repeat (6) tick();
    check("fall_no_irq", {31'd0, irq_v[0]}, 32'h0);
    check("fall_irq2", {31'd0, irq_v[2]}, 32'h1);

    in_port = 5'b00010;
    tick(); tick();
    bus_write(3'd2, 32'h02);
    address = 3'd2; tick();
    check("set_wins", rd_v[0] & 32'h2, 32'h2);
`else
    address = 3'd0; in_port = 5'b00000;
    repeat (10) tick();
    in_port = 5'b01000; repeat (3) tick();
    in_port = 5'b00000; repeat (12) tick();
    check("db_pulse3", rd_v[0] & 32'h8, 32'h0);
    in_port = 5'b01000; repeat (12) tick();
    check("db_hold", rd_v[0] & 32'h8, 32'h8);
    in_port = 5'b00000; repeat (3) tick();
    #2 reset_n = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    tick();
    check("db_reset", rd_v[0], 32'h0);
`endif

    bus_write(3'd1, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      in_port    = in_port ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      if (c % 700 == 350) begin
        #2 reset_n = 1'b0;
        tick();
        #2 reset_n = 1'b1;
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
